// File: rtl/fifo_pkt.sv
// fifo_pkt: first-word-fall-through packet FIFO with store-and-forward.
// The read side only sees words of packets whose last beat has been written.
// Optional feature macro: FIFO_PKT_ABORT_EN adds i_wabort, which drops the
// uncommitted partial packet by rewinding the write pointer to the commit pointer.
module fifo_pkt #(
   parameter int DATA_WIDTH   = 64,
   parameter int LOG2_DEPTH   = 5,
   parameter int AFULL_THRESH = (1 << LOG2_DEPTH) - 4
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic                  i_wvalid,
   input  logic [DATA_WIDTH-1:0] i_wdata,
   input  logic                  i_wlast,
   output logic                  o_wready,
`ifdef FIFO_PKT_ABORT_EN
   input  logic                  i_wabort,
`endif
   output logic                  o_rvalid,
   output logic [DATA_WIDTH-1:0] o_rdata,
   output logic                  o_rlast,
   input  logic                  i_rready,
   output logic [LOG2_DEPTH:0]   o_wcount,
   output logic [LOG2_DEPTH:0]   o_pkt_count,
   output logic                  o_almost_full
);

   localparam int PW = LOG2_DEPTH + 1;
   localparam int DEPTH = 1 << LOG2_DEPTH;
   localparam logic [PW-1:0] DEPTH_V = PW'(DEPTH);
   localparam logic [PW-1:0] AFULL_V = PW'(AFULL_THRESH);
   localparam logic [PW-1:0] ONE_V   = PW'(1);

   // Each entry carries its wlast flag above the payload.
   logic [DATA_WIDTH:0] r_mem [0:DEPTH-1];

   logic [PW-1:0] r_wr_ptr;
   logic [PW-1:0] r_cm_ptr;
   logic [PW-1:0] r_rd_ptr;
   logic [PW-1:0] r_pkt_count;
   logic          r_afull;

   logic [PW-1:0]       w_wcount;
   logic                w_full;
   logic                w_abort;
   logic                w_wr_en;
   logic                w_rd_en;
   logic                w_commit;
   logic                w_pop_last;
   logic                w_readable;
   logic [DATA_WIDTH:0] w_head;
   logic [PW-1:0]       w_wr_nxt;
   logic [PW-1:0]       w_cm_nxt;
   logic [PW-1:0]       w_rd_nxt;
   logic [PW-1:0]       w_wcount_nxt;

`ifdef FIFO_PKT_ABORT_EN
   assign w_abort = i_wabort;
`else
   assign w_abort = 1'b0;
`endif

   // Full is judged on registered pointers only, so a same-cycle pop never
   // opens a slot for a write at full.
   assign w_wcount   = r_wr_ptr - r_rd_ptr;
   assign w_full     = (w_wcount == DEPTH_V);
   assign o_wready   = ~w_full & ~i_rst;
   assign w_wr_en    = i_wvalid & o_wready & ~w_abort;
   assign w_commit   = w_wr_en & i_wlast;

   // Only committed words are visible; payload is forced to zero otherwise
   // so stale storage never leaks onto the read bus.
   assign w_readable = (r_rd_ptr != r_cm_ptr);
   assign w_head     = r_mem[r_rd_ptr[LOG2_DEPTH-1:0]];
   assign o_rvalid   = w_readable;
   assign o_rdata    = w_readable ? w_head[DATA_WIDTH-1:0] : '0;
   assign o_rlast    = w_readable & w_head[DATA_WIDTH];
   assign w_rd_en    = w_readable & i_rready;
   assign w_pop_last = w_rd_en & w_head[DATA_WIDTH];

   assign o_wcount      = w_wcount;
   assign o_pkt_count   = r_pkt_count;
   assign o_almost_full = r_afull;

   // Next-pointer selection; abort rewinds the speculative pointer and wins over write/commit.
   always_comb begin
      w_wr_nxt = r_wr_ptr;
      w_cm_nxt = r_cm_ptr;
      if (w_abort) begin
         w_wr_nxt = r_cm_ptr;
      end else if (w_wr_en) begin
         w_wr_nxt = r_wr_ptr + ONE_V;
         if (i_wlast) begin
            w_cm_nxt = r_wr_ptr + ONE_V;
         end
      end
      w_rd_nxt     = w_rd_en ? (r_rd_ptr + ONE_V) : r_rd_ptr;
      w_wcount_nxt = w_wr_nxt - w_rd_nxt;
   end

   // Storage write; no reset needed since readability is governed by the pointers.
   always_ff @(posedge i_clk) begin
      if (w_wr_en) begin
         r_mem[r_wr_ptr[LOG2_DEPTH-1:0]] <= {i_wlast, i_wdata};
      end
   end

   // Pointer, packet count and almost-full registers, all updated on the same edge.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_wr_ptr    <= '0;
         r_cm_ptr    <= '0;
         r_rd_ptr    <= '0;
         r_pkt_count <= '0;
         r_afull     <= 1'b0;
      end else begin
         r_wr_ptr <= w_wr_nxt;
         r_cm_ptr <= w_cm_nxt;
         r_rd_ptr <= w_rd_nxt;
         r_afull  <= (w_wcount_nxt >= AFULL_V);
         case ({w_commit, w_pop_last})
            2'b10:   r_pkt_count <= r_pkt_count + ONE_V;
            2'b01:   r_pkt_count <= r_pkt_count - ONE_V;
            default: r_pkt_count <= r_pkt_count;
         endcase
      end
   end

endmodule

// File: tb/tb_fifo_pkt.sv
// tb_fifo_pkt: scoreboard bench for fifo_pkt (LOG2_DEPTH=3, 16-bit data).
// Abort scenario is compiled in when FIFO_PKT_ABORT_EN is defined.
module tb_fifo_pkt;

   localparam int DW = 16;
   localparam int LD = 3;

   logic          i_clk = 1'b0;
   logic          i_rst = 1'b1;
   logic          i_wvalid = 1'b0;
   logic [DW-1:0] i_wdata = '0;
   logic          i_wlast = 1'b0;
   logic          o_wready;
`ifdef FIFO_PKT_ABORT_EN
   logic          i_wabort = 1'b0;
`endif
   logic          o_rvalid;
   logic [DW-1:0] o_rdata;
   logic          o_rlast;
   logic          i_rready = 1'b0;
   logic [LD:0]   o_wcount;
   logic [LD:0]   o_pkt_count;
   logic          o_almost_full;

   fifo_pkt #(.DATA_WIDTH(DW), .LOG2_DEPTH(LD)) dut (
      .i_clk        (i_clk),
      .i_rst        (i_rst),
      .i_wvalid     (i_wvalid),
      .i_wdata      (i_wdata),
      .i_wlast      (i_wlast),
      .o_wready     (o_wready),
`ifdef FIFO_PKT_ABORT_EN
      .i_wabort     (i_wabort),
`endif
      .o_rvalid     (o_rvalid),
      .o_rdata      (o_rdata),
      .o_rlast      (o_rlast),
      .i_rready     (i_rready),
      .o_wcount     (o_wcount),
      .o_pkt_count  (o_pkt_count),
      .o_almost_full(o_almost_full)
   );

   always #5 i_clk = ~i_clk;

   int n_checks = 0;
   int n_fail   = 0;
   logic [DW:0] exp_q [$];
   logic [DW:0] pend_q [$];
   logic oversize_seen = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   // Drive one beat for one cycle; accepted beats go to the pending packet,
   // which moves to the expected queue once its last beat is accepted.
   task automatic put(input logic [DW-1:0] d, input logic last, output logic acc);
      i_wvalid = 1'b1;
      i_wdata  = d;
      i_wlast  = last;
      acc      = o_wready;
      tick();
      if (acc) begin
         pend_q.push_back({last, d});
         if (last) begin
            while (pend_q.size() > 0) exp_q.push_back(pend_q.pop_front());
         end
      end
      i_wvalid = 1'b0;
      i_wlast  = 1'b0;
   endtask

   task automatic do_reset();
      i_rst    = 1'b1;
      i_wvalid = 1'b0;
      i_wlast  = 1'b0;
      #1;
      check("wready_in_rst", {31'b0, o_wready}, 32'd0);
      tick();
      i_rst = 1'b0;
      exp_q.delete();
      pend_q.delete();
      #1;
   endtask

   task automatic drain(input int bound);
      int n;
      n = 0;
      i_rready = 1'b1;
      while (exp_q.size() != 0 && n < bound) begin
         tick();
         n++;
      end
      check("drain_left", exp_q.size(), 32'd0);
      check("drain_rvalid", {31'b0, o_rvalid}, 32'd0);
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_rvalid"}, {31'b0, o_rvalid}, 32'd0);
      check({tag, "_rdata"}, {16'b0, o_rdata}, 32'd0);
      check({tag, "_rlast"}, {31'b0, o_rlast}, 32'd0);
      check({tag, "_wcount"}, {28'b0, o_wcount}, 32'd0);
      check({tag, "_pkt"}, {28'b0, o_pkt_count}, 32'd0);
      check({tag, "_afull"}, {31'b0, o_almost_full}, 32'd0);
      check({tag, "_wready"}, {31'b0, o_wready}, 32'd1);
   endtask

   // Monitor: compares each popped word against the scoreboard and flags any
   // visible word that the bench never committed.
   always @(negedge i_clk) begin
      logic [DW:0] e;
      if (!i_rst && o_rvalid) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_word actual=%h expected=none at %0t", {o_rlast, o_rdata}, $time);
         end else if (i_rready) begin
            e = exp_q.pop_front();
            check("pop_word", {15'b0, o_rlast, o_rdata}, {15'b0, e});
         end
      end
   end

   // Oversize-packet detector: storage full while holding no complete packet.
   always @(negedge i_clk) begin
      if (!i_rst && o_wcount == 4'd8 && o_pkt_count == 4'd0) oversize_seen = 1'b1;
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic acc;
      int nacc;
      int cyc;

      tick();
      tick();
      i_rst = 1'b0;
      #1;
      check_reset_vals("init");

      // Packet A: invisible until its last beat commits, then drains back-to-back.
      i_rready = 1'b1;
      put(16'hA000, 1'b0, acc);
      check("a0_rvalid", {31'b0, o_rvalid}, 32'd0);
      put(16'hA001, 1'b0, acc);
      check("a1_rvalid", {31'b0, o_rvalid}, 32'd0);
      check("a1_pkt", {28'b0, o_pkt_count}, 32'd0);
      put(16'hA002, 1'b1, acc);
      check("a2_rvalid", {31'b0, o_rvalid}, 32'd1);
      check("a2_rdata", {16'b0, o_rdata}, 32'h0000A000);
      check("a2_pkt", {28'b0, o_pkt_count}, 32'd1);
      tick();
      check("a_head1", {16'b0, o_rdata}, 32'h0000A001);
      tick();
      check("a_head2", {15'b0, o_rlast, o_rdata}, 32'h0001A002);
      check("a_pkt_last", {28'b0, o_pkt_count}, 32'd1);
      tick();
      check("a_pkt_end", {28'b0, o_pkt_count}, 32'd0);
      check("a_rvalid_end", {31'b0, o_rvalid}, 32'd0);

      // Fill with two 4-beat packets, no reader.
      i_rready = 1'b0;
      for (int i = 0; i < 8; i++) begin
         put(16'hB000 + 16'(i), (i == 3 || i == 7), acc);
         if (i == 2) check("afull_at3", {31'b0, o_almost_full}, 32'd0);
         if (i == 3) check("afull_at4", {31'b0, o_almost_full}, 32'd1);
      end
      check("fill_wready", {31'b0, o_wready}, 32'd0);
      check("fill_afull", {31'b0, o_almost_full}, 32'd1);
      check("fill_pkt", {28'b0, o_pkt_count}, 32'd2);
      check("fill_wcount", {28'b0, o_wcount}, 32'd8);
      put(16'hBEEF, 1'b1, acc);
      check("full_reject", {31'b0, acc}, 32'd0);
      check("full_wcount", {28'b0, o_wcount}, 32'd8);
      i_rready = 1'b1;
      tick();
      i_rready = 1'b0;
      check("pop1_wready", {31'b0, o_wready}, 32'd1);
      check("pop1_wcount", {28'b0, o_wcount}, 32'd7);
      drain(40);
      check("fill_pkt_end", {28'b0, o_pkt_count}, 32'd0);

      // Streaming 1-beat packets with a random reader; 100 writes wrap the 8-entry address 12 times.
      nacc = 0;
      cyc  = 0;
      while (nacc < 100 && cyc < 600) begin
         i_rready = ($urandom_range(0, 3) != 0);
         put(16'h4000 + 16'(nacc), 1'b1, acc);
         if (acc) nacc++;
         cyc++;
      end
      check("stream_written", nacc, 32'd100);
      drain(40);

`ifdef FIFO_PKT_ABORT_EN
      // Abort drops partial packet Q (including the beat offered with the abort).
      i_rready = 1'b0;
      put(16'hC000, 1'b0, acc);
      put(16'hC001, 1'b1, acc);
      put(16'hD000, 1'b0, acc);
      put(16'hD001, 1'b0, acc);
      put(16'hD002, 1'b0, acc);
      check("q_wcount", {28'b0, o_wcount}, 32'd5);
      i_wvalid = 1'b1;
      i_wdata  = 16'hD003;
      i_wabort = 1'b1;
      tick();
      i_wabort = 1'b0;
      i_wvalid = 1'b0;
      pend_q.delete();
      check("abort_wcount", {28'b0, o_wcount}, 32'd2);
      check("abort_pkt", {28'b0, o_pkt_count}, 32'd1);
      check("abort_head", {16'b0, o_rdata}, 32'h0000C000);
      drain(20);
      check("abort_wcount_end", {28'b0, o_wcount}, 32'd0);
      put(16'hC100, 1'b1, acc);
      drain(20);
`endif

      // Reset mid-packet with 5 entries held.
      i_rready = 1'b0;
      put(16'hE000, 1'b0, acc);
      put(16'hE001, 1'b1, acc);
      put(16'hE100, 1'b0, acc);
      put(16'hE101, 1'b0, acc);
      put(16'hE102, 1'b0, acc);
      check("pre_rst_wcount", {28'b0, o_wcount}, 32'd5);
      do_reset();
      check_reset_vals("midrst");
      i_rready = 1'b1;
      put(16'hF00D, 1'b1, acc);
      check("post_rst_head", {15'b0, o_rlast, o_rdata}, 32'h0001F00D);
      drain(20);

      check("no_false_oversize", {31'b0, oversize_seen}, 32'd0);

      // Illegal oversize packet: 8 beats with no wlast stall the FIFO.
      i_rready = 1'b1;
      for (int i = 0; i < 8; i++) put(16'h9000 + 16'(i), 1'b0, acc);
      check("ovs_wready", {31'b0, o_wready}, 32'd0);
      check("ovs_wcount", {28'b0, o_wcount}, 32'd8);
      check("ovs_rvalid", {31'b0, o_rvalid}, 32'd0);
      tick();
      check("ovs_detected", {31'b0, oversize_seen}, 32'd1);
      do_reset();
      check("ovs_rst_wcount", {28'b0, o_wcount}, 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
